// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline stage (pipe_stage_hs).
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_DATA_W = 64;
  localparam int unsigned DEFAULT_CNT_W  = 16;

  localparam int unsigned NPC_LSB   = 32;
  localparam int unsigned INSTR_LSB = 0;

  // Build an IF/ID payload from its next-PC and instruction fields.
  function automatic logic [63:0] ifid_pack(input logic [31:0] npc, input logic [31:0] instr);
    return (64'(npc) << NPC_LSB) | (64'(instr) << INSTR_LSB);
  endfunction

endpackage

// File: rtl/pipe_stage_hs_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  input  logic             clear_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_hs.sv
// Elastic pipeline register with valid/ready handshake, two-entry skid buffer and flush.
// Optional stall/flush statistics counters are enabled by defining PIPE_STAGE_STATS_EN.
module pipe_stage_hs
  import pipe_pkg::*;
#(
  parameter int unsigned           DATA_W     = DEFAULT_DATA_W,
  parameter logic [DATA_W-1:0]     RESET_DATA = '0,
  parameter int unsigned           CNT_W      = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_fire, out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      main_q  <= RESET_DATA;
      skid_q  <= RESET_DATA;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Next state and storage; flush overrides any transfer in the same cycle.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = RESET_DATA;
      skid_d  = RESET_DATA;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_d  = in_data;
            state_d = ST_BUSY;
          end
        end
        ST_BUSY: begin
          case ({in_fire, out_fire})
            2'b11:   main_d = in_data;
            2'b10: begin
              skid_d  = in_data;
              state_d = ST_FULL;
            end
            2'b01:   state_d = ST_EMPTY;
            default: state_d = ST_BUSY;
          endcase
        end
        ST_FULL: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = ST_BUSY;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Handshake flags decode the state register only.
  always_comb begin
    out_valid = 1'b0;
    in_ready  = 1'b1;
    if (state_q == ST_BUSY) begin
      out_valid = 1'b1;
    end else if (state_q == ST_FULL) begin
      out_valid = 1'b1;
      in_ready  = 1'b0;
    end
  end

  assign out_data = main_q;

`ifdef PIPE_STAGE_STATS_EN
  logic stall_inc, flush_inc;

  assign stall_inc = out_valid & ~out_ready & ~flush;
  assign flush_inc = flush & (state_q != ST_EMPTY);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (stall_inc),
    .clear_i (1'b0),
    .cnt_o   (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (flush_inc),
    .clear_i (1'b0),
    .cnt_o   (flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Self-checking bench for pipe_stage_hs: queue-based reference model plus directed literal checks.
module tb_pipe_stage_hs;
  import pipe_pkg::*;

  localparam int unsigned DW = 64;
`ifdef PIPE_STAGE_STATS_EN
  localparam int unsigned TB_CNT_W = 4;
`else
  localparam int unsigned TB_CNT_W = 16;
`endif
  localparam logic [DW-1:0] RST_VAL = '0;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                flush = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [DW-1:0]       in_data = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [DW-1:0]       out_data;
  logic [TB_CNT_W-1:0] stall_cnt;
  logic [TB_CNT_W-1:0] flush_cnt;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  pipe_stage_hs #(.DATA_W(DW), .RESET_DATA(RST_VAL), .CNT_W(TB_CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: an ordered list of held payloads, capacity two.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_last = RST_VAL;
  int            m_stall = 0;
  int            m_flush = 0;
  int            cnt_max;

  initial cnt_max = (1 << TB_CNT_W) - 1;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_last  = RST_VAL;
      m_stall = 0;
      m_flush = 0;
    end else begin
      bit ifire, ofire;
      ifire = in_valid && (mq.size() < 2);
      ofire = (mq.size() > 0) && out_ready;
      if ((mq.size() > 0) && !out_ready && !flush && m_stall < cnt_max) m_stall++;
      if (flush && (mq.size() > 0) && m_flush < cnt_max) m_flush++;
      if (flush) begin
        mq.delete();
        m_last = RST_VAL;
      end else begin
        if (ofire) m_last = mq.pop_front();
        if (ifire) mq.push_back(in_data);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [DW-1:0] exp_d;
      exp_d = (mq.size() > 0) ? mq[0] : m_last;
      check("model.out_valid", 64'(out_valid), 64'(mq.size() > 0));
      check("model.in_ready",  64'(in_ready),  64'(mq.size() < 2));
      check("model.out_data",  out_data, exp_d);
`ifdef PIPE_STAGE_STATS_EN
      check("model.stall_cnt", 64'(stall_cnt), 64'(m_stall));
      check("model.flush_cnt", 64'(flush_cnt), 64'(m_flush));
`else
      check("tied.stall_cnt", 64'(stall_cnt), 64'd0);
      check("tied.flush_cnt", 64'(flush_cnt), 64'd0);
`endif
    end
  end

  // Drive one cycle of inputs, then settle just past the following negedge.
  task automatic cyc(input bit iv, input logic [DW-1:0] id, input bit ordy, input bit fl);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] first_pl;
    logic [DW-1:0] pl_lit;

    repeat (2) @(negedge clk);
    #1;
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.in_ready",  64'(in_ready),  64'd1);
    check("rst.out_data",  out_data, 64'd0);
    @(negedge clk);
    reset  = 1'b0;
    chk_en = 1'b1;
    #1;

    // Streaming 1..8 at full throughput.
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, DW'(i), 1'b1, 1'b0);
      check("stream.out_data", out_data, 64'(i));
      check("stream.in_ready", 64'(in_ready), 64'd1);
    end
    cyc(1'b0, '0, 1'b1, 1'b0);
    check("stream.drain_valid", 64'(out_valid), 64'd0);
    check("stream.idle_data", out_data, 64'd8);

    // Back-pressure: A in main, B in skid, C held upstream.
    cyc(1'b1, 64'hA, 1'b0, 1'b0);
    check("bp.A_out", out_data, 64'hA);
    cyc(1'b1, 64'hB, 1'b0, 1'b0);
    check("bp.in_ready_full", 64'(in_ready), 64'd0);
    cyc(1'b1, 64'hC, 1'b0, 1'b0);
    check("bp.A_stable", out_data, 64'hA);
    check("bp.C_stalled", 64'(in_ready), 64'd0);
    cyc(1'b1, 64'hC, 1'b1, 1'b0);
    check("bp.B_out", out_data, 64'hB);
    cyc(1'b1, 64'hC, 1'b1, 1'b0);
    check("bp.C_out", out_data, 64'hC);
    cyc(1'b0, '0, 1'b1, 1'b0);
    check("bp.empty", 64'(out_valid), 64'd0);

    // Flush from FULL with a payload presented.
    cyc(1'b1, 64'h1A, 1'b0, 1'b0);
    cyc(1'b1, 64'h1B, 1'b0, 1'b0);
    cyc(1'b1, 64'hD, 1'b0, 1'b1);
    check("flush.out_valid", 64'(out_valid), 64'd0);
    check("flush.in_ready",  64'(in_ready),  64'd1);
    check("flush.data",      out_data, 64'd0);

    // Simultaneous in/out fire while BUSY.
    cyc(1'b1, 64'h55, 1'b0, 1'b0);
    cyc(1'b1, 64'h66, 1'b1, 1'b0);
    check("sim.Y_out",  out_data, 64'h66);
    check("sim.busy_v", 64'(out_valid), 64'd1);
    check("sim.busy_r", 64'(in_ready), 64'd1);
    cyc(1'b0, '0, 1'b1, 1'b0);

    // Long stall, then flush when BUSY and when EMPTY.
    cyc(1'b1, 64'h77, 1'b0, 1'b0);
    repeat (20) cyc(1'b0, '0, 1'b0, 1'b0);
    check("stall.hold", out_data, 64'h77);
`ifdef PIPE_STAGE_STATS_EN
    check("stats.stall_sat", 64'(stall_cnt), 64'd15);
    check("stats.flush_before", 64'(flush_cnt), 64'd1);
`endif
    cyc(1'b0, '0, 1'b0, 1'b1);
`ifdef PIPE_STAGE_STATS_EN
    check("stats.flush_busy", 64'(flush_cnt), 64'd2);
`endif
    cyc(1'b0, '0, 1'b0, 1'b1);
`ifdef PIPE_STAGE_STATS_EN
    check("stats.flush_empty", 64'(flush_cnt), 64'd2);
`endif

    // Async reset with two entries held.
    cyc(1'b1, 64'hE, 1'b0, 1'b0);
    cyc(1'b1, 64'hF, 1'b0, 1'b0);
    check("prerst.full", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    check("arst.out_valid", 64'(out_valid), 64'd0);
    check("arst.in_ready",  64'(in_ready),  64'd1);
    check("arst.out_data",  out_data, 64'd0);
    check("arst.stall_cnt", 64'(stall_cnt), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    first_pl = ifid_pack(32'h0000_0004, 32'h2002_0001);
    pl_lit   = 64'h0000_0004_2002_0001;
    check("pack.literal", first_pl, pl_lit);
    cyc(1'b1, first_pl, 1'b1, 1'b0);
    check("post.out_valid", 64'(out_valid), 64'd1);
    check("post.out_data", out_data, pl_lit);
    cyc(1'b0, '0, 1'b1, 1'b0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
